// File: rtl/des_final_permutation_stage.sv
// DES output stage: swaps L16/R16, applies FP = IP^-1, buffers results in a small FIFO.
// Optional FP_STATS_EN adds a saturating blk_count of delivered blocks.
module des_final_permutation_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       left_half,
  input  logic [31:0]       right_half,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       data_out
`ifdef FP_STATS_EN
  ,
  output logic [CNT_W-1:0]  blk_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  generate
    if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
      $error("DEPTH must be 2 or 4");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
    end
  endgenerate

  logic [63:0]   pre;
  logic [63:0]   fp;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          in_reset;
  logic          push;
  logic          pop;

  assign pre = {right_half, left_half};

  for (genvar k = 0; k < 64; k++) begin : g_fp
    assign fp[k] = pre[FP_TAB[k] - 1];
  end

  assign in_ready  = (count != FULL) && !in_reset;
  assign out_valid = (count != '0);
  // Gate the read so an empty buffer never exposes a stale block.
  assign data_out  = out_valid ? mem[rd_ptr] : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_reset <= 1'b1;
    end else begin
      in_reset <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fp;
  end

`ifdef FP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_count <= '0;
    end else if (pop && !flush && (blk_count != {CNT_W{1'b1}})) begin
      blk_count <= blk_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_des_final_permutation_stage.sv
// Bench for des_final_permutation_stage: directed handshake cases plus random round trips
// through the forward DES IP, scored against a queue model of the output FIFO.
module tb_des_final_permutation_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] left_half;
  logic [31:0] right_half;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
`ifdef FP_STATS_EN
  logic [CNT_W-1:0] blk_count;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_in;
  logic [63:0] q [$];
  logic        mon_en = 1'b0;
  logic        tb_in_reset = 1'b1;
  logic        rand_ph = 1'b0;

  des_final_permutation_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .left_half  (left_half),
    .right_half (right_half),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out)
`ifdef FP_STATS_EN
    ,
    .blk_count  (blk_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] ip_fwd(input logic [63:0] x);
    logic [63:0] r;
    for (int k = 0; k < 64; k++) r[k] = x[IP_TAB[k] - 1];
    return r;
  endfunction

  // Model: a queue of expected blocks; size is the occupancy.
  always @(posedge clk) tb_in_reset <= !rst_n;

  always @(negedge clk) begin
    if (mon_en) begin
      logic had;
      had = (q.size() != 0);
      check("out_valid", {63'd0, out_valid}, {63'd0, had});
      check("in_ready", {63'd0, in_ready},
            {63'd0, (q.size() != DEPTH) && !tb_in_reset});
      if (out_valid && had) check("data_out", data_out, q[0]);
      if (!rst_n || flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && had) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(exp_in);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ph) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [63:0] e);
    bit done = 0;
    left_half = l; right_half = r; exp_in = e; in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_x(input logic [63:0] x);
    logic [63:0] p;
    p = ip_fwd(x);
    send(p[31:0], p[63:32], x);
  endtask

  task automatic drain();
    bit done = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
    end
    check("drain", 64'(q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b1, b2, b3, x;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    left_half = '0; right_half = '0; exp_in = '0;
    tick();
    mon_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data_out", data_out, 64'd0);
`ifdef FP_STATS_EN
    check("rst_blk_count", 64'(blk_count), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Single-bit placement and known-vector round trip
    out_ready = 1'b1;
    send(32'h0, 32'h1, 64'h0100000000000000);
    @(negedge clk);
    check("bit_right_valid", {63'd0, out_valid}, 64'd1);
    check("bit_right", data_out, 64'h0100000000000000);
    tick();
    send(32'h1, 32'h0, 64'h0200000000000000);
    @(negedge clk);
    check("bit_left", data_out, 64'h0200000000000000);
    tick();
    send_x(64'h0123456789ABCDEF);
    @(negedge clk);
    check("roundtrip_vec", data_out, 64'h0123456789ABCDEF);
    tick();
    drain();

    // Backpressure: fill, hold off a third block, release one pop
    out_ready = 1'b0;
    b1 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
    send_x(b1);
    send_x(b2);
    @(negedge clk);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    x = ip_fwd(b3);
    left_half = x[31:0]; right_half = x[63:32]; exp_in = b3; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("held_in_ready", {63'd0, in_ready}, 64'd0);
      check("held_data", data_out, b1);
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("freed_in_ready", {63'd0, in_ready}, 64'd1);
    check("after_pop_data", data_out, b2);
    tick();
    in_valid = 1'b0;
    drain();

    // Simultaneous push and pop at count 1
    out_ready = 1'b0;
    b1 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    send_x(b1);
    x = ip_fwd(b2);
    left_half = x[31:0]; right_half = x[63:32]; exp_in = b2; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("concurrent_valid", {63'd0, out_valid}, 64'd1);
    check("concurrent_data", data_out, b2);
    tick();
    drain();

    // Flush with two entries
    out_ready = 1'b0;
    send_x({$urandom, $urandom});
    send_x({$urandom, $urandom});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    end
    tick();

    // Reset mid-stream
    out_ready = 1'b0;
    send_x({$urandom, $urandom});
    send_x({$urandom, $urandom});
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_data_out", data_out, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef FP_STATS_EN
    out_ready = 1'b1;
    repeat (5) send_x({$urandom, $urandom});
    drain();
    @(negedge clk);
    check("stats_5", 64'(blk_count), 64'd5);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("stats_flush", 64'(blk_count), 64'd5);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("stats_reset", 64'(blk_count), 64'd0);
    tick();
`endif

    // Random round trips with random backpressure
    rand_ph = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send_x({$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ph = 1'b0;
    #2;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
